// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: accumulator state
// names, the counter-width helper and the idle-timer width.
package fifo_pkg;

    // Packer state as seen from the accumulator fill count.
    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } fifo_pk_state_t;

    // Idle counter width; wide enough for TIMEOUT up to 255.
    localparam int unsigned PK_IDLE_W = 8;

    // Width of a counter that must hold 0..n inclusive (n a power of two).
    function automatic int unsigned clog2p1(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_idle_timer.sv
// Idle timer for the packer: counts cycles spent partially filled with no
// entry available and raises flush once TIMEOUT such cycles have elapsed.
// Only instantiated when FIFO_RD_PACKER_FLUSH_EN is defined.
module fifo_rd_packer_idle_timer
    import fifo_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic rclk,
    input  logic rrst_n,
    input  logic in_fill,   // accumulator holds a partial word
    input  logic pop,       // an entry is popped this cycle
    output logic flush
);

    localparam logic [PK_IDLE_W-1:0] IDLE_LAST = PK_IDLE_W'(TIMEOUT - 1);

    logic [PK_IDLE_W-1:0] idle_q, idle_d;

    // Next idle count: cleared outside FILL or on a pop, saturates at the
    // terminal value so a flush blocked by a busy output stays pending.
    always_comb begin
        idle_d = '0;
        if (in_fill && !pop) begin
            idle_d = (idle_q == IDLE_LAST) ? idle_q : idle_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign flush = in_fill && !pop && (idle_q == IDLE_LAST);

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops DSIZE-bit entries from the async FIFO's
// show-ahead port and packs RATIO of them (lane 0 first) into one word on a
// valid/ready stream. Defining FIFO_RD_PACKER_FLUSH_EN adds an idle-timeout
// flush that emits partial words with a lane keep mask.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE   = 8,
    parameter int unsigned RATIO   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic [DSIZE-1:0]         fifo_rdata,
    input  logic                     fifo_rempty,
    output logic                     fifo_rinc,
    output logic [DSIZE*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]         out_keep,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned    CW       = clog2p1(RATIO);
    localparam logic [CW-1:0]  CNT_FULL = CW'(RATIO);

    // Elaboration-time parameter sanity checks.
    if (RATIO < 2 || RATIO > 16 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("fifo_rd_packer: RATIO must be a power of two in 2..16");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fifo_rd_packer: TIMEOUT must be in 2..255");
    end

    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DSIZE-1:0]         lane_q [RATIO];
    logic [DSIZE-1:0]         lane_d [RATIO];
    logic [DSIZE*RATIO-1:0]   data_q, data_d;
    logic [RATIO-1:0]         keep_q, keep_d;
    logic                     valid_q, valid_d;

    fifo_pk_state_t           state;
    logic                     slot_free;
    logic                     flush;
    logic                     xfer;
    logic                     pop;
    logic [CW-1:0]            wr_idx;
    logic [DSIZE*RATIO-1:0]   acc_word;
    logic [RATIO-1:0]         acc_keep;

    // State is a pure decode of the fill count.
    always_comb begin
        if (cnt_q == '0) begin
            state = EMPTY;
        end else if (cnt_q == CNT_FULL) begin
            state = FULL;
        end else begin
            state = FILL;
        end
    end

`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic in_fill;
    assign in_fill = (state == FILL);

    // In FILL a pop happens exactly when the FIFO is non-empty, so the timer
    // looks at !fifo_rempty rather than fifo_rinc to keep flush off the
    // xfer -> fifo_rinc path.
    fifo_rd_packer_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .in_fill (in_fill),
        .pop     (!fifo_rempty),
        .flush   (flush)
    );
`else
    assign flush = 1'b0;
`endif

    assign slot_free = !valid_q || out_ready;
    assign xfer      = ((state == FULL) || flush) && slot_free;
    assign pop       = !fifo_rempty && ((state != FULL) || xfer);
    assign fifo_rinc = pop;

    // Flatten the accumulator lanes and build the keep mask for a transfer.
    always_comb begin
        acc_word = '0;
        acc_keep = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            acc_word[k*DSIZE +: DSIZE] = lane_q[k];
`ifdef FIFO_RD_PACKER_FLUSH_EN
            acc_keep[k] = (CW'(k) < cnt_q);
`else
            acc_keep[k] = 1'b1;
`endif
        end
    end

    // Accumulator next state: a transfer empties it, and a pop in the same
    // cycle lands in lane 0 of the freshly cleared accumulator.
    always_comb begin
        cnt_d  = cnt_q;
        wr_idx = xfer ? '0 : cnt_q;
        for (int unsigned k = 0; k < RATIO; k++) begin
            lane_d[k] = xfer ? '0 : lane_q[k];
        end
        if (xfer) begin
            cnt_d = '0;
        end
        if (pop) begin
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (CW'(k) == wr_idx) begin
                    lane_d[k] = fifo_rdata;
                end
            end
            cnt_d = wr_idx + 1'b1;
        end
    end

    // Output register next state: load on transfer, drop valid on accept.
    always_comb begin
        data_d  = data_q;
        keep_d  = keep_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = acc_word;
            keep_d  = acc_keep;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Accumulator registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q <= '0;
            for (int unsigned k = 0; k < RATIO; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int unsigned k = 0; k < RATIO; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    // Single-entry output register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue stands in for the FIFO, a queue-based
// model predicts every output each cycle, and directed scenarios pin the
// model with literal words, latencies and keep masks.
module tb_fifo_rd_packer;

    localparam int unsigned DSIZE   = 8;
    localparam int unsigned RATIO   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned W       = DSIZE * RATIO;

    logic             rclk        = 1'b0;
    logic             rrst_n      = 1'b0;
    logic [DSIZE-1:0] fifo_rdata  = '0;
    logic             fifo_rempty = 1'b1;
    logic             fifo_rinc;
    logic [W-1:0]     out_data;
    logic [RATIO-1:0] out_keep;
    logic             out_valid;
    logic             out_ready   = 1'b0;

    fifo_rd_packer #(
        .DSIZE   (DSIZE),
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge rclk) cyc <= cyc + 1;

    // FIFO contents and the pop decision seen in the current cycle.
    logic [DSIZE-1:0] fq [$];
    bit               pop_now = 1'b0;

    // Model: entries gathered so far, and the word sitting at the output.
    logic [DSIZE-1:0] m_acc [$];
    bit               m_full = 1'b0;
    logic [W-1:0]     m_data = '0;
    logic [RATIO-1:0] m_keep = '0;
    int               m_idle = 0;

    // Words accepted downstream, as seen on the DUT ports.
    logic [W-1:0]     log_data [$];
    logic [RATIO-1:0] log_keep [$];
    int               log_cyc  [$];
    int               rinc_cnt  = 0;
    int               valid_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge rclk) begin
        bit sf;
        bit fl;
        bit xf;
        bit er;
        int n;
        #1;
        if (!rrst_n) begin
            m_acc.delete();
            m_full  = 1'b0;
            m_idle  = 0;
            pop_now = 1'b0;
        end else begin
            n = m_acc.size();
            chk("out_valid", 64'(out_valid), 64'(m_full));
            if (m_full) begin
                chk("out_data", 64'(out_data), 64'(m_data));
                chk("out_keep", 64'(out_keep), 64'(m_keep));
            end
            sf = !m_full || out_ready;
            fl = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            fl = (n > 0) && (n < int'(RATIO)) && fifo_rempty && (m_idle == int'(TIMEOUT) - 1);
`endif
            xf = ((n == int'(RATIO)) || fl) && sf;
            er = !fifo_rempty && ((n < int'(RATIO)) || xf);
            chk("fifo_rinc", 64'(fifo_rinc), 64'(er));
            pop_now = fifo_rinc;
            if (fifo_rinc) rinc_cnt++;
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready) begin
                log_data.push_back(out_data);
                log_keep.push_back(out_keep);
                log_cyc.push_back(cyc);
            end
            // Consecutive idle cycles while partially filled, saturating.
            if (n > 0 && n < int'(RATIO) && !er) begin
                m_idle = (m_idle < int'(TIMEOUT) - 1) ? m_idle + 1 : m_idle;
            end else begin
                m_idle = 0;
            end
            if (xf) begin
                m_data = '0;
                for (int i = 0; i < n; i++) m_data[i*DSIZE +: DSIZE] = m_acc[i];
                m_keep = RATIO'((1 << n) - 1);
                m_full = 1'b1;
                m_acc.delete();
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
            if (er) m_acc.push_back(fifo_rdata);
        end
    end

    function automatic void refresh();
        if (!rrst_n || fq.size() == 0) begin
            fifo_rempty = 1'b1;
            fifo_rdata  = DSIZE'($urandom);
        end else begin
            fifo_rempty = 1'b0;
            fifo_rdata  = fq[0];
        end
    endfunction

    // Advance one clock: retire the entry popped at this edge, then present
    // the new FIFO head just after the edge.
    task automatic step();
        @(posedge rclk);
        if (pop_now && fq.size() > 0) void'(fq.pop_front());
        #1;
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        log_data.delete();
        log_keep.delete();
        log_cyc.delete();
    endtask

    initial begin
        int cs;
        int r0;
        int v0;
        logic [W-1:0] held;

        // Reset state.
        steps(3);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_keep", 64'(out_keep), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_fifo_rinc", 64'(fifo_rinc), 64'd0);
        rrst_n = 1'b1;

        // Empty FIFO throughout: nothing popped, nothing emitted.
        out_ready = 1'b1;
        r0 = rinc_cnt;
        v0 = valid_cnt;
        steps(20);
        chk("empty_rinc_count", 64'(rinc_cnt - r0), 64'd0);
        chk("empty_valid_count", 64'(valid_cnt - v0), 64'd0);
        chk("empty_out_data", 64'(out_data), 64'd0);

        // One word, 0x11..0x44.
        clear_log();
        v0 = valid_cnt;
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        step();
        cs = cyc;
        steps(10);
        chk("w1_count", 64'(log_data.size()), 64'd1);
        chk("w1_data", 64'(log_data[0]), 64'h4433_2211);
        chk("w1_keep", 64'(log_keep[0]), 64'hF);
        chk("w1_latency", 64'(log_cyc[0] - cs), 64'd5);
        chk("w1_valid_cycles", 64'(valid_cnt - v0), 64'd1);

        // Sixteen bytes back to back.
        clear_log();
        for (int i = 0; i < 16; i++) fq.push_back(DSIZE'(i));
        step();
        cs = cyc;
        r0 = rinc_cnt;
        steps(16);
        chk("stream_rinc_continuous", 64'(rinc_cnt - r0), 64'd16);
        steps(8);
        chk("stream_count", 64'(log_data.size()), 64'd4);
        chk("stream_first_latency", 64'(log_cyc[0] - cs), 64'd5);
        for (int i = 0; i < 4; i++) begin
            chk("stream_data", 64'(log_data[i]), 64'(32'h0302_0100 + 32'h0404_0404 * i));
            chk("stream_spacing", 64'(log_cyc[i] - log_cyc[0]), 64'(4 * i));
        end

        // Backpressure with 12 bytes queued.
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) fq.push_back(DSIZE'(8'h40 + i));
        step();
        steps(12);
        held = out_data;
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(held), 64'h4342_4140);
        chk("stall_rinc", 64'(fifo_rinc), 64'd0);
        chk("stall_fifo_left", 64'(fq.size()), 64'd4);
        steps(3);
        chk("stall_stable", 64'(out_data), 64'(held));
        out_ready = 1'b1;
        steps(14);
        chk("stall_count", 64'(log_data.size()), 64'd3);
        chk("stall_w0", 64'(log_data[0]), 64'h4342_4140);
        chk("stall_w1", 64'(log_data[1]), 64'h4746_4544);
        chk("stall_w2", 64'(log_data[2]), 64'h4B4A_4948);

        // Two bytes then idle.
        clear_log();
        fq.push_back(8'hAA); fq.push_back(8'hBB);
        step();
        cs = cyc;
        steps(TIMEOUT + 8);
`ifdef FIFO_RD_PACKER_FLUSH_EN
        chk("flush_count", 64'(log_data.size()), 64'd1);
        chk("flush_data", 64'(log_data[0]), 64'h0000_BBAA);
        chk("flush_keep", 64'(log_keep[0]), 64'h3);
        chk("flush_latency", 64'(log_cyc[0] - cs), 64'(TIMEOUT + 2));
`else
        chk("noflush_count", 64'(log_data.size()), 64'd0);
        fq.push_back(8'hCC); fq.push_back(8'hDD);
        step();
        steps(8);
        chk("noflush_done_count", 64'(log_data.size()), 64'd1);
        chk("noflush_done_data", 64'(log_data[0]), 64'hDDCC_BBAA);
        chk("noflush_done_keep", 64'(log_keep[0]), 64'hF);
`endif

        // Reset mid-word with a stalled output word.
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) fq.push_back(DSIZE'(8'h60 + i));
        step();
        steps(6);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rrst_n = 1'b0;
        fq.delete();
        refresh();
        #1;
        chk("mid_reset_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_keep", 64'(out_keep), 64'd0);
        chk("mid_reset_data", 64'(out_data), 64'd0);
        chk("mid_reset_rinc", 64'(fifo_rinc), 64'd0);
        steps(2);
        rrst_n = 1'b1;
        out_ready = 1'b1;
        clear_log();
        for (int i = 0; i < 4; i++) fq.push_back(DSIZE'(8'h70 + i));
        step();
        steps(8);
        chk("post_reset_count", 64'(log_data.size()), 64'd1);
        chk("post_reset_data", 64'(log_data[0]), 64'h7372_7170);
        chk("post_reset_keep", 64'(log_keep[0]), 64'hF);

        // Random traffic and backpressure, checked every cycle by the model.
        for (int i = 0; i < 1500; i++) begin
            if (fq.size() < 16 && $urandom_range(0, 3) != 0) begin
                for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                    fq.push_back(DSIZE'($urandom));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if ((i / 200) % 3 == 2) out_ready = ($urandom_range(0, 4) == 0);
            step();
        end
        out_ready = 1'b1;
        steps(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It pops DSIZE-bit entries through the FIFO's show-ahead read port (rdata, rinc, rempty) and packs RATIO consecutive entries, lane 0 first, into one wide word. The word is presented on a valid/ready output stream. An optional idle-timeout flush emits partial words with a lane keep mask.

## Interface
- DSIZE, 8, width of one FIFO entry (must match the FIFO's DSIZE)
- RATIO, 4, entries per output word; power of two, 2..16
- TIMEOUT, 16, idle cycles before a partial word is flushed (flush build only); 2..255

- rclk  in  1  read-domain clock; all state updates on the rising edge
- rrst_n  in  1  asynchronous, active-low reset
- fifo_rdata  in  DSIZE  FIFO head entry; valid combinationally whenever fifo_rempty=0
- fifo_rempty  in  1  FIFO empty flag (registered inside the FIFO)
- fifo_rinc  out  1  pop strobe to the FIFO; combinational
- out_data  out  DSIZE*RATIO  packed word; lane k = bits [k*DSIZE +: DSIZE]
- out_keep  out  RATIO  per-lane valid mask
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word when out_valid && out_ready

## Operation
- The datapath has an accumulator (RATIO lanes plus count cnt, 0..RATIO) and a single-entry output register (out_data, out_keep, out_valid).
- The FSM is derived from cnt:
  - EMPTY: cnt=0.
  - FILL: 0<cnt<RATIO.
  - FULL: cnt=RATIO.
- slot_free = !out_valid || out_ready.
- xfer = (FULL && slot_free) || (flush && slot_free).
  - On xfer, the accumulator lanes, keep mask and valid=1 load into the output register.
  - Unfilled lanes load as 0 data and 0 keep.
- fifo_rinc = !fifo_rempty && (cnt<RATIO || xfer). It is never asserted while fifo_rempty=1.
- On a pop, fifo_rdata is written to lane cnt and cnt increments.
  - If xfer happens in the same cycle, the popped entry goes to lane 0 and cnt becomes 1.
  - The other lanes clear.
- On xfer without a pop, cnt becomes 0.
- FULL with the slot occupied and out_ready=0: no pop and no transfer; everything holds.
- On out_valid && out_ready without a new xfer, out_valid clears. out_data and out_keep hold their last value.
- Transitions:
  - EMPTY -> FILL on a pop.
  - FILL -> FULL on the RATIO-th pop.
  - FULL -> FILL on xfer with a pop.
  - FULL -> EMPTY on xfer without a pop.
  - FILL -> EMPTY on flush.
- Reset: cnt=0, all lanes 0, out_valid=0, out_data=0, out_keep=0, idle counter 0.
  - fifo_rinc reads 0 during reset because the FIFO holds rempty=1 in reset.
  - Reset asserted mid-word discards the accumulator and the output register without emitting anything.

## Timing
- A pop is a single-cycle combinational handshake: fifo_rinc high at rising edge t captures fifo_rdata at edge t.
- The last entry of a word is captured at edge t. out_valid rises at edge t+1 if the slot is free at that edge.
- Sustained throughput with out_ready=1 and the FIFO non-empty is one word every RATIO cycles, because pop and transfer overlap.
- out_data and out_keep are stable while out_valid && !out_ready.
- out_ready is ignored while out_valid=0. No combinational path runs from out_ready to out_valid.
- Combinational paths exist only from fifo_rempty and out_ready to fifo_rinc.

## Configuration
- FIFO_RD_PACKER_FLUSH_EN defined:
  - An idle counter increments each cycle in FILL with no pop. It resets on any pop and in EMPTY/FULL.
  - flush asserts when the counter equals TIMEOUT-1 in a cycle with no pop.
  - A pending flush waits in FILL until slot_free; the counter saturates meanwhile.
  - out_keep = (1<<cnt)-1 for a partial word.
- Undefined:
  - No counter and flush is 0. Partial words wait indefinitely.
  - out_keep is all ones whenever out_valid=1. TIMEOUT is unused.

## Structure
- Shared package fifo_pkg holds:
  - the state enum fifo_pk_state_t {EMPTY, FILL, FULL};
  - the function clog2p1(n), used for the cnt width ($clog2(RATIO)+1);
  - localparam PK_IDLE_W = 8 for the idle counter width.
- One sub-module, fifo_rd_packer_idle_timer, holds the idle counter and flush compare. It is instantiated only under FIFO_RD_PACKER_FLUSH_EN.

## Test plan
- Load bytes 0x11,0x22,0x33,0x44 with out_ready=1 and default params. Required: out_data=0x44332211, out_keep=4'hF, out_valid for exactly 1 cycle, 1 cycle after the 4th pop.
- Stream 16 bytes back-to-back with out_ready=1. Required: 4 words 0x03020100..0x0F0E0D0C, one word every 4 cycles, fifo_rinc continuously high.
- Hold out_ready=0 with 12 bytes queued. Required: first word held stable, accumulator FULL, fifo_rinc=0 with 4 bytes left in the FIFO. Raise out_ready: remaining words follow in order with no loss or duplication.
- fifo_rempty=1 throughout. Required: fifo_rinc never 1, out_valid stays 0, out_data=0.
- Flush build, 2 bytes 0xAA,0xBB then idle. Required: after TIMEOUT idle cycles, out_data=0x0000BBAA and out_keep=4'h3. Non-flush build: no output.
- Assert rrst_n low after 2 pops and while out_valid=1 is stalled. Required: out_valid=0, out_keep=0, cnt=0 immediately. The next 4 bytes form a clean word.
